// File: rtl/mem_pkg.sv
// Shared types and helpers for the dual-port memory: access-size encoding,
// access width in bytes and byte-lane write masks.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } access_size_e;

    // Widest supported word is 64 bits, so masks never need more than 8 lanes.
    localparam int unsigned MaxLanes = 8;

    // Number of bytes touched by an access of the given size (2^size).
    function automatic int unsigned access_bytes(input logic [1:0] size);
        return 32'd1 << size;
    endfunction

    // Lane mask for an access of `size` starting at `lane`; callers truncate
    // to their own DWIDTH/8 lanes.
    function automatic logic [MaxLanes-1:0] byte_mask(input logic [1:0] size,
                                                      input logic [2:0] lane);
        logic [MaxLanes-1:0] ones;
        case (access_size_e'(size))
            SZ_B:    ones = 8'h01;
            SZ_H:    ones = 8'h03;
            SZ_W:    ones = 8'h0F;
            default: ones = 8'hFF;
        endcase
        return ones << lane;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load alignment: shifts the addressed bytes of a raw storage word down to
// bit 0 and sign- or zero-extends them to the full data width.
module mem_load_align #(
    parameter int unsigned DWIDTH = 32
) (
    input  logic [DWIDTH-1:0]             raw_i,
    input  logic [$clog2(DWIDTH/8)-1:0]   lane_i,
    input  logic [1:0]                    size_i,
    input  logic                          unsigned_i,
    output logic [DWIDTH-1:0]             data_o
);

    localparam int unsigned SelW = $clog2(DWIDTH);

    logic [DWIDTH-1:0] shifted;
    logic [DWIDTH-1:0] low_mask;
    logic [SelW-1:0]   top_bit;
    int unsigned       nbits;
    logic              sign;

    // Right-align the selected bytes, then fill the upper bits with the sign or zeros
    always_comb begin
        shifted  = raw_i >> {lane_i, 3'b000};
        nbits    = 32'd8 << size_i;
        if (nbits >= DWIDTH) begin
            low_mask = '1;
            top_bit  = SelW'(DWIDTH - 1);
        end else begin
            low_mask = (DWIDTH'(1) << nbits) - DWIDTH'(1);
            top_bit  = SelW'(nbits - 1);
        end
        sign   = !unsigned_i && shifted[top_bit];
        data_o = (shifted & low_mask) | (sign ? ~low_mask : '0);
    end

endmodule

// File: rtl/dual_port_memory.sv
// Dual-port memory: a read-only instruction port and a load/store data port
// sharing one word array. Both ports respond one cycle after the request with
// a registered valid/err/data triple; illegal accesses never touch storage.
module dual_port_memory
    import mem_pkg::*;
#(
    parameter int unsigned       AWIDTH      = 32,
    parameter int unsigned       DWIDTH      = 32,
    parameter int unsigned       DEPTH_WORDS = 1024,
    parameter logic [AWIDTH-1:0] BASE_ADDR   = AWIDTH'(32'h0100_0000),
    parameter string             INIT_FILE   = ""
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              imem_req_i,
    input  logic [AWIDTH-1:0] imem_addr_i,
    output logic [DWIDTH-1:0] imem_data_o,
    output logic              imem_valid_o,
    output logic              imem_err_o,

    input  logic [AWIDTH-1:0] dmem_addr_i,
    input  logic [DWIDTH-1:0] dmem_data_i,
    input  logic              dmem_read_en_i,
    input  logic              dmem_write_en_i,
    input  logic [1:0]        dmem_size_i,
    input  logic              dmem_unsigned_i,
    output logic [DWIDTH-1:0] dmem_data_o,
    output logic              dmem_valid_o,
    output logic              dmem_err_o
);

    localparam int unsigned NB       = DWIDTH / 8;
    localparam int unsigned LaneW    = $clog2(NB);
    localparam int unsigned IdxW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned MemBytes = DEPTH_WORDS * NB;

    // Offset is computed with wrap-around, so the lower-bound test uses the address itself.
    function automatic logic in_range(input logic [AWIDTH-1:0] addr,
                                      input logic [AWIDTH-1:0] off,
                                      input int unsigned       nbytes);
        logic [AWIDTH:0] end_off;
        end_off = {1'b0, off} + (AWIDTH+1)'(nbytes);
        return (addr >= BASE_ADDR) && (end_off <= (AWIDTH+1)'(MemBytes));
    endfunction

    logic [DWIDTH-1:0] mem_q [DEPTH_WORDS];

    // Data port decode
    logic [AWIDTH-1:0] d_off;
    logic [LaneW-1:0]  d_lane;
    logic [IdxW-1:0]   d_idx;
    int unsigned       d_nbytes;
    logic              d_req;
    logic              d_illegal;
    logic              d_load_ok;
    logic              d_store_ok;
    logic [NB-1:0]     d_mask;
    logic [DWIDTH-1:0] d_wdata;
    logic [DWIDTH-1:0] d_raw;
    logic [DWIDTH-1:0] d_load_data;

    // Instruction port decode
    logic [AWIDTH-1:0] i_off;
    logic [IdxW-1:0]   i_idx;
    logic              i_legal;

    // Output registers
    logic [DWIDTH-1:0] imem_data_d, imem_data_q;
    logic              imem_valid_d, imem_valid_q;
    logic              imem_err_d, imem_err_q;
    logic [DWIDTH-1:0] dmem_data_d, dmem_data_q;
    logic              dmem_valid_d, dmem_valid_q;
    logic              dmem_err_d, dmem_err_q;

    // Decode the data-port request: range, size, alignment and read/write conflict
    always_comb begin
        d_off      = dmem_addr_i - BASE_ADDR;
        d_lane     = d_off[LaneW-1:0];
        d_idx      = d_off[LaneW +: IdxW];
        d_nbytes   = access_bytes(dmem_size_i);
        d_req      = dmem_read_en_i || dmem_write_en_i;
        d_illegal  = (d_nbytes > NB)
                  || ((32'(d_lane) & (d_nbytes - 32'd1)) != 32'd0)
                  || !in_range(dmem_addr_i, d_off, d_nbytes)
                  || (dmem_read_en_i && dmem_write_en_i);
        d_load_ok  = dmem_read_en_i && !dmem_write_en_i && !d_illegal;
        d_store_ok = dmem_write_en_i && !dmem_read_en_i && !d_illegal;
        d_mask     = NB'(byte_mask(dmem_size_i, 3'(d_lane)));
        d_wdata    = dmem_data_i << {d_lane, 3'b000};
        d_raw      = d_load_ok ? mem_q[d_idx] : '0;
    end

    mem_load_align #(
        .DWIDTH (DWIDTH)
    ) u_load_align (
        .raw_i      (d_raw),
        .lane_i     (d_lane),
        .size_i     (dmem_size_i),
        .unsigned_i (dmem_unsigned_i),
        .data_o     (d_load_data)
    );

    // Decode the instruction port: whole-word, naturally aligned, in range
    always_comb begin
        i_off   = imem_addr_i - BASE_ADDR;
        i_idx   = i_off[LaneW +: IdxW];
        i_legal = in_range(imem_addr_i, i_off, NB) && (i_off[LaneW-1:0] == '0);
    end

    // Next-state values of the response registers
    always_comb begin
        imem_valid_d = imem_req_i;
        imem_err_d   = imem_req_i && !i_legal;
        imem_data_d  = (imem_req_i && i_legal) ? mem_q[i_idx] : '0;
        dmem_valid_d = d_req;
        dmem_err_d   = d_req && d_illegal;
        dmem_data_d  = d_load_ok ? d_load_data : '0;
    end

    // Byte-lane store; reset suppresses the write but never clears contents
    always_ff @(posedge clk) begin
        if (rst && d_store_ok) begin
            for (int l = 0; l < int'(NB); l++) begin
                if (d_mask[l]) begin
                    mem_q[d_idx][8*l +: 8] <= d_wdata[8*l +: 8];
                end
            end
        end
    end

    // Response registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            imem_data_q  <= '0;
            imem_valid_q <= 1'b0;
            imem_err_q   <= 1'b0;
            dmem_data_q  <= '0;
            dmem_valid_q <= 1'b0;
            dmem_err_q   <= 1'b0;
        end else begin
            imem_data_q  <= imem_data_d;
            imem_valid_q <= imem_valid_d;
            imem_err_q   <= imem_err_d;
            dmem_data_q  <= dmem_data_d;
            dmem_valid_q <= dmem_valid_d;
            dmem_err_q   <= dmem_err_d;
        end
    end

    assign imem_data_o  = imem_data_q;
    assign imem_valid_o = imem_valid_q;
    assign imem_err_o   = imem_err_q;
    assign dmem_data_o  = dmem_data_q;
    assign dmem_valid_o = dmem_valid_q;
    assign dmem_err_o   = dmem_err_q;

endmodule
